// File: rtl/rat_recovery_ctrl.sv
// rat_recovery_ctrl
//   Sequences pipeline recovery after a flush: waits for retirement to drain,
//   pulses the retire-RAT -> spec-RAT flash copy, snapshots the retire-RAT
//   physical-mapping bitmaps and walks them one chunk per cycle to rebuild the
//   INT and FP free lists. Rename stays stalled until the rebuild completes.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   flush_req              recovery request (pulse or level)
//   retire_busy            retire ports still writing the retire RAT
//   Int/Fp_RetirePhyMapBits  1 = physical register mapped in retire RAT
//   rename_stall           hold rename/dispatch (any non-idle state)
//   spec_flash_we          Spec_RAT flash-write strobe
//   fl_clear               empty both free lists
//   fl_push_*              one free-list chunk push per walk cycle
//   int_free_cnt/fp_free_cnt  free counts accumulated by the walk
//   recovery_done          one-cycle completion pulse
module rat_recovery_ctrl #(
    parameter int unsigned INT_PRF_DEPTH = 64,
    parameter int unsigned FP_PRF_DEPTH  = 64,
    parameter int unsigned WALK_WIDTH    = 8
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                flush_req,
    input  logic                                                retire_busy,
    input  logic [INT_PRF_DEPTH-1:0]                            Int_RetirePhyMapBits,
    input  logic [FP_PRF_DEPTH-1:0]                             Fp_RetirePhyMapBits,
    output logic                                                rename_stall,
    output logic                                                spec_flash_we,
    output logic                                                fl_clear,
    output logic                                                fl_push_valid,
    output logic                                                fl_push_isFP,
    output logic [$clog2((INT_PRF_DEPTH > FP_PRF_DEPTH) ? INT_PRF_DEPTH : FP_PRF_DEPTH)-1:0] fl_push_base,
    output logic [WALK_WIDTH-1:0]                               fl_push_mask,
    output logic [$clog2(INT_PRF_DEPTH):0]                      int_free_cnt,
    output logic [$clog2(FP_PRF_DEPTH):0]                       fp_free_cnt,
    output logic                                                recovery_done
);

    localparam int unsigned MAX_DEPTH  = (INT_PRF_DEPTH > FP_PRF_DEPTH) ? INT_PRF_DEPTH : FP_PRF_DEPTH;
    localparam int unsigned BASE_W     = $clog2(MAX_DEPTH);
    localparam int unsigned INT_CHUNKS = INT_PRF_DEPTH / WALK_WIDTH;
    localparam int unsigned FP_CHUNKS  = FP_PRF_DEPTH / WALK_WIDTH;
    localparam int unsigned MAX_CHUNKS = MAX_DEPTH / WALK_WIDTH;
    localparam int unsigned CNT_W      = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;
    localparam int unsigned LOG_W      = $clog2(WALK_WIDTH);
    localparam int unsigned INT_CW     = $clog2(INT_PRF_DEPTH) + 1;
    localparam int unsigned FP_CW      = $clog2(FP_PRF_DEPTH) + 1;
    localparam int unsigned PC_W       = $clog2(WALK_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE, DRAIN, FLASH, SNAP, WALK_INT, WALK_FP, DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         walk_cnt_q, walk_cnt_d;
    logic                     pending_q, pending_d;
    logic [INT_PRF_DEPTH-1:0] snap_int_q, snap_int_d;
    logic [FP_PRF_DEPTH-1:0]  snap_fp_q, snap_fp_d;
    logic [INT_CW-1:0]        int_cnt_q, int_cnt_d;
    logic [FP_CW-1:0]         fp_cnt_q, fp_cnt_d;

    logic [BASE_W-1:0]        chunk_base;
    logic [WALK_WIDTH-1:0]    int_mask;
    logic [WALK_WIDTH-1:0]    fp_mask;

    function automatic logic [PC_W-1:0] popcnt(input logic [WALK_WIDTH-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < WALK_WIDTH; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // Chunk masks come from the snapshot flops only, so pushed data is
    // immune to bitmap changes after SNAP.
    always_comb begin
        chunk_base = BASE_W'(walk_cnt_q) << LOG_W;
        int_mask   = ~snap_int_q[chunk_base +: WALK_WIDTH];
        fp_mask    = ~snap_fp_q[chunk_base +: WALK_WIDTH];
        // INT p0 backs x0 and must never enter the free list.
        if (walk_cnt_q == '0) begin
            int_mask[0] = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            walk_cnt_q <= '0;
            pending_q  <= 1'b0;
            snap_int_q <= '0;
            snap_fp_q  <= '0;
            int_cnt_q  <= '0;
            fp_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            walk_cnt_q <= walk_cnt_d;
            pending_q  <= pending_d;
            snap_int_q <= snap_int_d;
            snap_fp_q  <= snap_fp_d;
            int_cnt_q  <= int_cnt_d;
            fp_cnt_q   <= fp_cnt_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        walk_cnt_d = walk_cnt_q;
        pending_d  = pending_q;
        snap_int_d = snap_int_q;
        snap_fp_d  = snap_fp_q;
        int_cnt_d  = int_cnt_q;
        fp_cnt_d   = fp_cnt_q;

        if (state_q != IDLE && flush_req) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (flush_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!retire_busy) state_d = FLASH;
            end
            FLASH: state_d = SNAP;
            SNAP: begin
                snap_int_d = Int_RetirePhyMapBits;
                snap_fp_d  = Fp_RetirePhyMapBits;
                walk_cnt_d = '0;
                int_cnt_d  = '0;
                fp_cnt_d   = '0;
                state_d    = WALK_INT;
            end
            WALK_INT: begin
                int_cnt_d = int_cnt_q + INT_CW'(popcnt(int_mask));
                if (walk_cnt_q == CNT_W'(INT_CHUNKS - 1)) begin
                    walk_cnt_d = '0;
                    state_d    = WALK_FP;
                end else begin
                    walk_cnt_d = walk_cnt_q + 1'b1;
                end
            end
            WALK_FP: begin
                fp_cnt_d = fp_cnt_q + FP_CW'(popcnt(fp_mask));
                if (walk_cnt_q == CNT_W'(FP_CHUNKS - 1)) begin
                    walk_cnt_d = '0;
                    state_d    = DONE;
                end else begin
                    walk_cnt_d = walk_cnt_q + 1'b1;
                end
            end
            DONE: begin
                // A request landing in DONE itself is folded into the same
                // restart so it cannot be stranded as a pending bit in IDLE.
                pending_d = 1'b0;
                state_d   = (pending_q || flush_req) ? DRAIN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from flops only
    always_comb begin
        rename_stall  = (state_q != IDLE);
        spec_flash_we = (state_q == FLASH);
        fl_clear      = (state_q == FLASH);
        recovery_done = (state_q == DONE);
        fl_push_valid = 1'b0;
        fl_push_isFP  = 1'b0;
        fl_push_base  = '0;
        fl_push_mask  = '0;
        int_free_cnt  = int_cnt_q;
        fp_free_cnt   = fp_cnt_q;
        if (state_q == WALK_INT) begin
            fl_push_valid = 1'b1;
            fl_push_base  = chunk_base;
            fl_push_mask  = int_mask;
        end else if (state_q == WALK_FP) begin
            fl_push_valid = 1'b1;
            fl_push_isFP  = 1'b1;
            fl_push_base  = chunk_base;
            fl_push_mask  = fp_mask;
        end
    end

endmodule

// File: tb/tb_rat_recovery_ctrl.sv
// Testbench for rat_recovery_ctrl: table of bitmap scenarios run through full
// recovery sequences, plus hand-written pending-flush and mid-walk reset cases.
module tb_rat_recovery_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_req;
    logic        retire_busy;
    logic [63:0] int_map;
    logic [63:0] fp_map;
    logic        rename_stall;
    logic        spec_flash_we;
    logic        fl_clear;
    logic        fl_push_valid;
    logic        fl_push_isFP;
    logic [5:0]  fl_push_base;
    logic [7:0]  fl_push_mask;
    logic [6:0]  int_free_cnt;
    logic [6:0]  fp_free_cnt;
    logic        recovery_done;

    int total = 0;
    int bad   = 0;

    rat_recovery_ctrl #(
        .INT_PRF_DEPTH(64),
        .FP_PRF_DEPTH (64),
        .WALK_WIDTH   (8)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush_req           (flush_req),
        .retire_busy         (retire_busy),
        .Int_RetirePhyMapBits(int_map),
        .Fp_RetirePhyMapBits (fp_map),
        .rename_stall        (rename_stall),
        .spec_flash_we       (spec_flash_we),
        .fl_clear            (fl_clear),
        .fl_push_valid       (fl_push_valid),
        .fl_push_isFP        (fl_push_isFP),
        .fl_push_base        (fl_push_base),
        .fl_push_mask        (fl_push_mask),
        .int_free_cnt        (int_free_cnt),
        .fp_free_cnt         (fp_free_cnt),
        .recovery_done       (recovery_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] int_map;
        logic [63:0] fp_map;
        int          drain;     // extra cycles retire_busy is held in DRAIN
        logic [6:0]  exp_int;
        logic [6:0]  exp_fp;
        logic [7:0]  exp_m0;    // INT chunk 0 mask
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, rename_stall, 0);
        chk({tag, "_flash"}, spec_flash_we, 0);
        chk({tag, "_clear"}, fl_clear, 0);
        chk({tag, "_valid"}, fl_push_valid, 0);
        chk({tag, "_isfp"},  fl_push_isFP, 0);
        chk({tag, "_base"},  fl_push_base, 0);
        chk({tag, "_mask"},  fl_push_mask, 0);
        chk({tag, "_icnt"},  int_free_cnt, 0);
        chk({tag, "_fcnt"},  fp_free_cnt, 0);
        chk({tag, "_done"},  recovery_done, 0);
    endtask

    // Runs one recovery. do_flush=0 means the DUT is already in DRAIN.
    // reflush = number of flush pulses injected during WALK_FP.
    task automatic run_seq(input vec_t v, input bit do_flush, input int reflush);
        logic [7:0] e;
        int acc;
        int_map = v.int_map;
        fp_map  = v.fp_map;
        if (do_flush) begin
            flush_req   = 1'b1;
            retire_busy = 1'b0;
            step();
            flush_req = 1'b0;
        end
        for (int i = 0; i < v.drain; i++) begin
            retire_busy = 1'b1;
            chk("drain_stall", rename_stall, 1);
            chk("drain_noflash", spec_flash_we, 0);
            step();
        end
        retire_busy = 1'b0;
        chk("drain_stall", rename_stall, 1);
        chk("drain_noflash", spec_flash_we, 0);
        chk("drain_nodone", recovery_done, 0);
        step();
        chk("flash_we", spec_flash_we, 1);
        chk("flash_clear", fl_clear, 1);
        chk("flash_nopush", fl_push_valid, 0);
        step();
        chk("snap_noflash", spec_flash_we, 0);
        chk("snap_nopush", fl_push_valid, 0);
        chk("snap_stall", rename_stall, 1);
        step();
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            e = v.int_map[k*8 +: 8];
            e = ~e;
            if (k == 0) e[0] = 1'b0;
            chk("int_valid", fl_push_valid, 1);
            chk("int_isfp", fl_push_isFP, 0);
            chk("int_base", fl_push_base, 64'(k * 8));
            chk("int_mask", fl_push_mask, e);
            if (k == 0) chk("int_m0", fl_push_mask, v.exp_m0);
            chk("int_cnt_run", int_free_cnt, 64'(acc));
            acc += $countones(e);
            // Bitmaps after SNAP must not influence pushes.
            int_map = {$urandom(), $urandom()};
            fp_map  = {$urandom(), $urandom()};
            step();
        end
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            e = v.fp_map[k*8 +: 8];
            e = ~e;
            flush_req = (reflush > 0 && k == 2) || (reflush > 1 && k == 5);
            chk("fp_valid", fl_push_valid, 1);
            chk("fp_isfp", fl_push_isFP, 1);
            chk("fp_base", fl_push_base, 64'(k * 8));
            chk("fp_mask", fl_push_mask, e);
            chk("fp_cnt_run", fp_free_cnt, 64'(acc));
            acc += $countones(e);
            int_map = {$urandom(), $urandom()};
            fp_map  = {$urandom(), $urandom()};
            step();
            flush_req = 1'b0;
        end
        chk("done_pulse", recovery_done, 1);
        chk("done_stall", rename_stall, 1);
        chk("done_nopush", fl_push_valid, 0);
        chk("done_int_cnt", int_free_cnt, v.exp_int);
        chk("done_fp_cnt", fp_free_cnt, v.exp_fp);
        step();
        chk("post_done", recovery_done, 0);
        if (reflush > 0) begin
            chk("redrain_stall", rename_stall, 1);
            chk("redrain_noflash", spec_flash_we, 0);
        end else begin
            chk("idle_stall", rename_stall, 0);
            chk("idle_int_hold", int_free_cnt, v.exp_int);
            chk("idle_fp_hold", fp_free_cnt, v.exp_fp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{int_map: 64'h0000_0000_FFFF_FFFE, fp_map: 64'h0000_0000_FFFF_FFFF,
                    drain: 0, exp_int: 7'd32, exp_fp: 7'd32, exp_m0: 8'h00};
        vecs[1] = '{int_map: 64'h0, fp_map: 64'h0,
                    drain: 0, exp_int: 7'd63, exp_fp: 7'd64, exp_m0: 8'hFE};
        vecs[2] = '{int_map: 64'hFFFF_FFFF_FFFF_FFFF, fp_map: 64'hFFFF_FFFF_FFFF_FFFF,
                    drain: 1, exp_int: 7'd0, exp_fp: 7'd0, exp_m0: 8'h00};
        vecs[3] = '{int_map: 64'hAAAA_AAAA_AAAA_AAAA, fp_map: 64'h5555_5555_5555_5555,
                    drain: 5, exp_int: 7'd31, exp_fp: 7'd32, exp_m0: 8'h54};
        vecs[4] = '{int_map: 64'h0F0F_0F0F_0F0F_0F0F, fp_map: 64'hFFFF_0000_0000_0000,
                    drain: 2, exp_int: 7'd32, exp_fp: 7'd48, exp_m0: 8'hF0};

        rst         = 1'b1;
        flush_req   = 1'b0;
        retire_busy = 1'b0;
        int_map     = '0;
        fp_map      = '0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk("idle_after_reset", rename_stall, 0);

        for (int i = 0; i < 5; i++) begin
            run_seq(vecs[i], 1'b1, 0);
            step();
        end

        // Two flush pulses during WALK_FP coalesce into exactly one rerun.
        run_seq(vecs[0], 1'b1, 2);
        run_seq(vecs[1], 1'b0, 0);
        step();

        // Reset in the middle of WALK_INT aborts to IDLE.
        int_map   = vecs[4].int_map;
        fp_map    = vecs[4].fp_map;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        step();
        step();
        step();
        chk("mid_walk_push", fl_push_valid, 1);
        chk("mid_walk_base", fl_push_base, 8);
        rst = 1'b1;
        step();
        chk_all_zero("mid_reset");
        rst = 1'b0;
        step();
        chk("mid_reset_idle", rename_stall, 0);
        run_seq(vecs[3], 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rat_recovery_ctrl.md
Name: rat_recovery_ctrl

Overview:
- Sequences pipeline recovery after a flush (branch mispredict or exception).
- Waits for in-flight retirement to drain, then pulses the flash-copy of the retire RAT into the speculative RAT.
- Snapshots the retire-RAT physical-mapping bitmaps and walks them a chunk per cycle to rebuild the INT and FP free lists.
- Holds the rename stage stalled until the rebuild completes. Sits between the commit/flush logic, Retire_RAT, Spec_RAT and the free-list unit.

Parameters:
- INT_PRF_DEPTH, 64, number of INT physical registers; must be a multiple of WALK_WIDTH.
- FP_PRF_DEPTH, 64, number of FP physical registers; must be a multiple of WALK_WIDTH.
- WALK_WIDTH, 8, bitmap entries examined per walk cycle; must be a power of 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_req  in  1  recovery request pulse/level
- retire_busy  in  1  retire ports still writing the retire RAT this cycle
- Int_RetirePhyMapBits  in  INT_PRF_DEPTH  1 = INT phy reg mapped in retire RAT
- Fp_RetirePhyMapBits  in  FP_PRF_DEPTH  1 = FP phy reg mapped in retire RAT
- rename_stall  out  1  hold rename/dispatch
- spec_flash_we  out  1  Spec_RAT flash-write strobe
- fl_clear  out  1  empty both free lists
- fl_push_valid  out  1  push chunk valid
- fl_push_isFP  out  1  chunk type (1 = FP)
- fl_push_base  out  clog2(max(INT_PRF_DEPTH,FP_PRF_DEPTH))  phy index of chunk bit 0
- fl_push_mask  out  WALK_WIDTH  bit i = phy reg (base+i) is free
- int_free_cnt  out  clog2(INT_PRF_DEPTH)+1  INT free count after rebuild
- fp_free_cnt  out  clog2(FP_PRF_DEPTH)+1  FP free count after rebuild
- recovery_done  out  1  one-cycle completion pulse

Behaviour:
- FSM states: IDLE, DRAIN, FLASH, SNAP, WALK_INT, WALK_FP, DONE.
- All outputs are registered or decoded from state/counter/snapshot flops only; no input-to-output combinational path.
- Reset: state = IDLE, walk counter = 0, pending = 0, snapshots = 0. All outputs read 0, including both free counts.
- A reset asserted mid-operation aborts immediately to IDLE; a partially pushed free list is not completed.
- IDLE: flush_req=1 → DRAIN.
- DRAIN: stay while retire_busy=1; on retire_busy=0 → FLASH.
- FLASH (1 cycle): spec_flash_we=1, fl_clear=1 → SNAP.
- SNAP (1 cycle): capture both bitmaps into snapshot registers; clear walk counter and both free-count accumulators → WALK_INT.
- WALK_INT: one cycle per chunk k, for k = 0 .. INT_PRF_DEPTH/WALK_WIDTH−1.
  - Drives fl_push_valid=1, fl_push_isFP=0, fl_push_base = k*WALK_WIDTH, fl_push_mask = ~snapshot chunk.
  - Bit 0 of chunk 0 is forced to 0: INT p0 belongs to x0 and is never freed.
  - int_free_cnt += popcount(mask) each cycle.
  - After the last chunk → WALK_FP with the counter cleared.
- WALK_FP: same procedure over the FP bitmap with fl_push_isFP=1 and no p0 exclusion; accumulates fp_free_cnt. After the last chunk → DONE.
- DONE (1 cycle): recovery_done=1. Goes to DRAIN if pending=1 (and clears pending), else to IDLE.
- rename_stall = 1 in every state except IDLE.
- A flush_req arriving in any non-IDLE state sets pending; multiple such requests coalesce into one.
- Free counts hold their value from DONE until the next SNAP.
- Latency with default parameters, flush_req sampled at cycle N and retire_busy=0:
  - DRAIN N+1, FLASH N+2, SNAP N+3
  - WALK_INT N+4..N+11, WALK_FP N+12..N+19
  - DONE N+20, IDLE N+21
  - rename_stall high N+1..N+20.
- Each cycle spent in DRAIN adds one cycle to the whole sequence.
- Bitmap changes after SNAP do not affect pushed data.

Test Plan:
- Post-reset mapping (INT map p1..p31, FP map p0..p31), flush at cycle N → spec_flash_we and fl_clear at N+2; 16 pushes; masks: INT chunks 0–3 = 0x00, chunks 4–7 = 0xFF; int_free_cnt=32, fp_free_cnt=32; recovery_done at N+20.
- retire_busy held high 5 cycles after flush → FLASH delayed to N+7, recovery_done at N+25, rename_stall continuous from N+1.
- INT bitmap all zeros → chunk 0 mask = 0xFE; int_free_cnt = 63.
- flush_req pulsed again during WALK_FP → DONE is followed by DRAIN; second full sequence runs; recovery_done pulses twice.
- Bitmap inputs toggled randomly during WALK_INT → pushed masks equal the SNAP-cycle snapshot.
- rst asserted during WALK_INT → next cycle: IDLE, all outputs 0; subsequent flush runs a normal full sequence.
